// File: rtl/fp_special_pipe.sv
// Two-stage special-operand classifier with operation-aware ind/dz flags and valid/ready flow control.
// Optional sticky status registers are built when FP_SPECIAL_STICKY_EN is defined.
module fp_special_pipe #(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned FRAC_W = 23,
  parameter int unsigned TAG_W  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [1+EXP_W+FRAC_W-1:0]    opa,
  input  logic [1+EXP_W+FRAC_W-1:0]    opb,
  input  logic [1:0]                   op,
  input  logic [TAG_W-1:0]             in_tag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [TAG_W-1:0]             out_tag,
  output logic                         opa_zero,
  output logic                         opa_dn,
  output logic                         opa_inf,
  output logic                         opa_qnan,
  output logic                         opa_snan,
  output logic                         opb_zero,
  output logic                         opb_dn,
  output logic                         opb_inf,
  output logic                         opb_qnan,
  output logic                         opb_snan,
  output logic                         inf,
  output logic                         qnan,
  output logic                         snan,
  output logic                         ind,
  output logic                         dz,
  input  logic                         sticky_clr,
  output logic                         sticky_ind,
  output logic                         sticky_snan,
  output logic                         sticky_dz
);

  localparam int unsigned W       = 1 + EXP_W + FRAC_W;
  localparam int unsigned FLAGS_W = 15;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef struct packed {
    logic sign;
    logic e1;
    logic e0;
    logic f0;
    logic fm;
  } dec_t;

  // Raw exponent/fraction predicates; full classification is deferred to stage 2.
  function automatic dec_t decode(input logic [W-1:0] x);
    dec_t d;
    d.sign = x[W-1];
    d.e1   = &x[W-2:FRAC_W];
    d.e0   = ~|x[W-2:FRAC_W];
    d.f0   = ~|x[FRAC_W-1:0];
    d.fm   = x[FRAC_W-1];
    return d;
  endfunction

  // Returns {zero, dn, inf, qnan, snan}.
  function automatic logic [4:0] classify(input dec_t d);
    return {d.e0 & d.f0, d.e0 & ~d.f0, d.e1 & d.f0, d.e1 & d.fm, d.e1 & ~d.fm & ~d.f0};
  endfunction

  logic               s1_valid;
  dec_t               s1_a;
  dec_t               s1_b;
  logic [1:0]         s1_op;
  logic [TAG_W-1:0]   s1_tag;
  logic               s2_adv;
  logic [FLAGS_W-1:0] flags_d;
  logic [FLAGS_W-1:0] flags_q;

  assign s2_adv   = ~out_valid | out_ready;
  assign in_ready = ~s1_valid | s2_adv;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
      s1_tag   <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a   <= decode(opa);
        s1_b   <= decode(opb);
        s1_op  <= op;
        s1_tag <= in_tag;
      end
    end
  end

  always_comb begin
    logic [4:0] ca;
    logic [4:0] cb;
    logic       any_nan;
    logic       both_inf;
    logic       ind_raw;
    logic       dz_c;
    ca       = classify(s1_a);
    cb       = classify(s1_b);
    any_nan  = ca[1] | ca[0] | cb[1] | cb[0];
    both_inf = ca[2] & cb[2];
    ind_raw  = 1'b0;
    case (s1_op)
      OP_ADD:  ind_raw = both_inf & (s1_a.sign ^ s1_b.sign);
      OP_SUB:  ind_raw = both_inf & ~(s1_a.sign ^ s1_b.sign);
      OP_MUL:  ind_raw = (ca[2] & cb[4]) | (ca[4] & cb[2]);
      OP_DIV:  ind_raw = both_inf | (ca[4] & cb[4]);
      default: ind_raw = 1'b0;
    endcase
    dz_c    = (s1_op == OP_DIV) & cb[4] & ~ca[4] & ~ca[2] & ~any_nan;
    flags_d = {ca, cb, ca[2] | cb[2], ca[1] | cb[1], ca[0] | cb[0], ind_raw & ~any_nan, dz_c};
  end

  // Stage 2 only loads when the consumer can take it, so a stalled result holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_tag   <= '0;
      flags_q   <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_tag <= s1_tag;
        flags_q <= flags_d;
      end
    end
  end

  assign {opa_zero, opa_dn, opa_inf, opa_qnan, opa_snan,
          opb_zero, opb_dn, opb_inf, opb_qnan, opb_snan,
          inf, qnan, snan, ind, dz} = flags_q;

`ifdef FP_SPECIAL_STICKY_EN
  logic [2:0] sticky_q;
  logic       out_hs;

  assign out_hs = out_valid & out_ready;

  // A setting event in the same cycle as a clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= (sticky_q & {3{~sticky_clr}}) | ({3{out_hs}} & {ind, snan, dz});
    end
  end

  assign {sticky_ind, sticky_snan, sticky_dz} = sticky_q;
`else
  logic sticky_clr_unused;

  assign sticky_clr_unused = sticky_clr;
  assign {sticky_ind, sticky_snan, sticky_dz} = 3'b000;
`endif

endmodule

// File: doc/fp_special_pipe.md
# fp_special_pipe

Parametrised, pipelined special-number classifier for two IEEE-754-style operands. Decodes zero, denormal, infinity, quiet NaN and signalling NaN for each operand, and produces operation-aware combined exception flags (invalid/indeterminate, divide-by-zero) for add, sub, mul and div. Sits between operand issue and the FPU arithmetic pipes. A valid/ready handshake with full backpressure and an optional sticky status register make it a drop-in front end for any precision.

## Interface
- EXP_W, 8, exponent width
- FRAC_W, 23, fraction width; operand width W = 1+EXP_W+FRAC_W
- TAG_W, 4, opaque tag carried alongside each operand pair
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts the pair this cycle
- opa, opb  in  W  operands {sign, exp, frac}
- op  in  2  operation: 00 add, 01 sub, 10 mul, 11 div
- in_tag  in  TAG_W  tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_tag  out  TAG_W  tag of the result
- opa_zero/opa_dn/opa_inf/opa_qnan/opa_snan  out  1 each  operand A class
- opb_zero/opb_dn/opb_inf/opb_qnan/opb_snan  out  1 each  operand B class
- inf, qnan, snan  out  1 each  OR of the per-operand flags
- ind  out  1  invalid operation (see Operation)
- dz  out  1  divide by zero
- sticky_clr  in  1  clear sticky flags
- sticky_ind, sticky_snan, sticky_dz  out  1 each  accumulated flags

## Operation
- Per operand: e1 = &exp, e0 = ~|exp, f0 = ~|frac, fm = frac[FRAC_W-1].
- zero = e0&f0. dn = e0&~f0. A zero is never a denormal.
- inf = e1&f0. qnan = e1&fm. snan = e1&~fm&~f0.
- ind is set for these cases, and only when neither operand is a NaN:
  - add: both operands inf, signs differ.
  - sub: both operands inf, signs equal.
  - mul: one operand inf, the other zero.
  - div: both operands inf, or both operands zero.
- dz = div & opb_zero & ~opa_zero & ~opa_inf & no NaN present.
- Stage 1 registers e1, e0, f0, fm, both signs, op and tag. Stage 2 registers every output flag.
- Handshake:
  - s2_adv = ~out_valid | out_ready.
  - in_ready = ~s1_valid | s2_adv.
  - Transfer happens on valid & ready at each interface. Pairs are never dropped, duplicated or reordered.
  - Output flags and out_tag hold stable while out_valid & ~out_ready.
- Reset:
  - Clears both stage valids.
  - All outputs read 0: flags, out_tag, out_valid and sticky bits.
  - in_ready reads 1 from the first cycle after reset.
  - Reset asserted mid-stream discards in-flight pairs.

## Timing
- Latency: 2 cycles, from accept edge to out_valid high. Throughput: 1 pair per cycle when out_ready is held high.
- With out_ready low, two pairs fill the pipe. in_ready then drops combinationally in the same cycle.
- in_ready depends combinationally on out_ready. No other input-to-output combinational path exists.
- Sticky flags update on the edge of an output handshake, so they are visible the cycle after the handshake.
- Simultaneous sticky_clr and a setting event: set wins and the bit reads 1.
- sticky_clr alone clears on the next edge.

## Configuration
- FP_SPECIAL_STICKY_EN defined: sticky_ind, sticky_snan and sticky_dz are three registers. Each ORs in ind, snan and dz respectively on every out_valid&out_ready, and is cleared by sticky_clr.
- FP_SPECIAL_STICKY_EN undefined: the sticky registers are not built. The sticky outputs are tied to 0, sticky_clr is ignored, and the ports remain present.

## Test plan
- Reset, then opa=0x7F800000, opb=0xFF800000, op=add, out_ready=1 -> 2 cycles later: out_valid=1, opa_inf=opb_inf=inf=ind=1, dz=0.
- opa=0x7F800000, opb=0x00000000, op=mul -> ind=1, opb_zero=1. The same operands with op=add -> ind=0, inf=1.
- opa=0x3F800000, opb=0x80000000, op=div -> dz=1, ind=0. opa=0, opb=0, op=div -> ind=1, dz=0.
- opa=0x7FA00000, opb=0x00000001 -> opa_snan=snan=1, opb_dn=1, opb_zero=0. opa=0x7FC00000 with opb=0x7F800000 and op=sub -> qnan=1, ind=0.
- Backpressure: stream 6 tagged pairs with out_ready toggling 1,0,0,1,… -> in_ready drops after two stalled pairs. The outputs hold stable while stalled. Tags emerge 0..5 in order with no loss.
- With FP_SPECIAL_STICKY_EN: an ind result sets sticky_ind=1; it stays 1 across later clean results. sticky_clr in the same cycle as an snan handshake -> sticky_snan=1 and sticky_ind=0. Assert reset mid-stream -> all outputs 0 and out_valid=0 on the next cycle.
